// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one SPRITE_W x SPRITE_H sprite from a ROM into the SRAM
// back buffer by read-modify-write of packed words, with transparency, unaligned X
// and screen clipping. Optional mirroring: define SPRITE_BLITTER_FLIP_EN for Flip_X.
module sprite_blitter #(
  parameter int unsigned SPRITE_W    = 16,
  parameter int unsigned SPRITE_H    = 16,
  parameter int unsigned PIX_BITS    = 4,
  parameter int unsigned WORD_BITS   = 16,
  parameter int unsigned NUM_SPRITES = 2,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned TRANSPARENT = 0,
  localparam int unsigned ID_BITS    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
`ifdef SPRITE_BLITTER_FLIP_EN
  input  logic                 Flip_X,
`endif
  input  logic                 Start,
  input  logic [ID_BITS-1:0]   Sprite_Id,
  input  logic [9:0]           ImgX,
  input  logic [9:0]           ImgY,
  input  logic                 Back_Sel,
  output logic                 Busy,
  output logic                 Done,
  output logic [ID_BITS-1:0]   Rom_Sel,
  output logic [11:0]          Rom_Addr,
  input  logic [PIX_BITS-1:0]  Rom_Data,
  output logic                 Mem_Req,
  input  logic                 Mem_Gnt,
  output logic                 Mem_WE_N,
  output logic [19:0]          Mem_Addr,
  output logic [WORD_BITS-1:0] Mem_Wdata,
  input  logic [WORD_BITS-1:0] Mem_Rdata
);

  localparam int unsigned PPW = WORD_BITS / PIX_BITS;
  localparam int unsigned XW  = 11;                  // pixel / word coordinate width
  localparam int unsigned RW  = 7;                   // sprite row counter width
  localparam int unsigned AW  = 12;                  // ROM address width
  localparam int unsigned MW  = $clog2(PPW + 2);     // merge slot counter width

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, MERGE, WR_REQ, NEXT, DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_n_q, mem_we_n_d;
  logic [AW-1:0]        rom_addr_q, rom_addr_d;
  logic [ID_BITS-1:0]   sel_q, sel_d;
  logic                 bsel_q, bsel_d;
  logic [XW-1:0]        x0_q, x0_d;            // latched ImgX
  logic [XW-1:0]        xb0_q, xb0_d;          // first word's leftmost pixel x
  logic [XW-1:0]        w0_q, w0_d;
  logic [XW-1:0]        w1_q, w1_d;
  logic [XW-1:0]        w_q, w_d;
  logic [XW-1:0]        xbase_q, xbase_d;      // leftmost pixel x of current word
  logic [RW-1:0]        r_q, r_d;
  logic [XW-1:0]        y_q, y_d;
  logic [AW-1:0]        row_base_q, row_base_d;
  logic [MW-1:0]        m_q, m_d;
  logic [WORD_BITS-1:0] buf_q, buf_d;
`ifdef SPRITE_BLITTER_FLIP_EN
  logic                 flip_q, flip_d;
`endif

  // launch-time span and slot helpers
  logic [XW-1:0] l_w0, l_w1, l_xe, l_cap;
  logic [MW-1:0] a_slot, d_slot;
  logic [XW-1:0] px_a, px_d, col_a;
  logic          ok_a, ok_d;

  function automatic logic slot_ok(input logic [XW-1:0] px, input logic [XW-1:0] x0);
    return (px >= x0) && ((px - x0) < XW'(SPRITE_W)) && (px < XW'(SCREEN_W));
  endfunction

  // state and datapath registers
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_n_q <= 1'b1;
      rom_addr_q <= '0;
      sel_q      <= '0;
      bsel_q     <= 1'b0;
      x0_q       <= '0;
      xb0_q      <= '0;
      w0_q       <= '0;
      w1_q       <= '0;
      w_q        <= '0;
      xbase_q    <= '0;
      r_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      m_q        <= '0;
      buf_q      <= '0;
`ifdef SPRITE_BLITTER_FLIP_EN
      flip_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_req_q  <= mem_req_d;
      mem_we_n_q <= mem_we_n_d;
      rom_addr_q <= rom_addr_d;
      sel_q      <= sel_d;
      bsel_q     <= bsel_d;
      x0_q       <= x0_d;
      xb0_q      <= xb0_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      w_q        <= w_d;
      xbase_q    <= xbase_d;
      r_q        <= r_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      m_q        <= m_d;
      buf_q      <= buf_d;
`ifdef SPRITE_BLITTER_FLIP_EN
      flip_q     <= flip_d;
`endif
    end
  end

  // next-state, pixel merge pipeline and registered output values
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    rom_addr_d = rom_addr_q;
    sel_d      = sel_q;
    bsel_d     = bsel_q;
    x0_d       = x0_q;
    xb0_d      = xb0_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    w_d        = w_q;
    xbase_d    = xbase_q;
    r_d        = r_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    m_d        = m_q;
    buf_d      = buf_q;
`ifdef SPRITE_BLITTER_FLIP_EN
    flip_d     = flip_q;
`endif

    l_w0  = XW'(ImgX) / XW'(PPW);
    l_xe  = XW'(ImgX) + XW'(SPRITE_W - 1);
    l_cap = XW'((SCREEN_W - 1) / PPW);
    l_w1  = ((l_xe / XW'(PPW)) < l_cap) ? (l_xe / XW'(PPW)) : l_cap;

    // ROM address runs one slot ahead of the data being merged
    a_slot = (state_q == RD_WAIT) ? '0 : MW'(m_q + MW'(1));
    d_slot = MW'(m_q - MW'(1));
    px_a   = xbase_q + XW'(a_slot);
    px_d   = xbase_q + XW'(d_slot);
    ok_a   = slot_ok(px_a, x0_q);
    ok_d   = slot_ok(px_d, x0_q);
    col_a  = px_a - x0_q;
`ifdef SPRITE_BLITTER_FLIP_EN
    if (flip_q) col_a = XW'(SPRITE_W - 1) - col_a;
`endif

    case (state_q)
      IDLE: begin
        if (Start) begin
          busy_d     = 1'b1;
          sel_d      = Sprite_Id;
          bsel_d     = Back_Sel;
          x0_d       = XW'(ImgX);
          w0_d       = l_w0;
          w1_d       = l_w1;
          xb0_d      = l_w0 * XW'(PPW);
          w_d        = l_w0;
          xbase_d    = l_w0 * XW'(PPW);
          r_d        = '0;
          y_d        = XW'(ImgY);
          row_base_d = '0;
`ifdef SPRITE_BLITTER_FLIP_EN
          flip_d     = Flip_X;
`endif
          // nothing visible: spend one cycle in NEXT so Busy still pulses
          if ((XW'(ImgY) < XW'(SCREEN_H)) && (l_w0 <= l_w1)) state_d = RD_REQ;
          else                                                state_d = NEXT;
        end
      end
      RD_REQ: begin
        if (Mem_Gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        buf_d   = Mem_Rdata;
        m_d     = '0;
        state_d = MERGE;
      end
      MERGE: begin
        if (m_q != '0 && ok_d && Rom_Data != PIX_BITS'(TRANSPARENT)) begin
          for (int unsigned s = 0; s < PPW; s++) begin
            if (MW'(s) == d_slot) buf_d[s*PIX_BITS +: PIX_BITS] = Rom_Data;
          end
        end
        if (m_q == MW'(PPW)) begin
          m_d     = '0;
          state_d = WR_REQ;
        end else begin
          m_d = MW'(m_q + MW'(1));
        end
      end
      WR_REQ: begin
        if (Mem_Gnt) state_d = NEXT;
      end
      NEXT: begin
        if (!((y_q < XW'(SCREEN_H)) && (w0_q <= w1_q))) begin
          state_d = DONE;
        end else if (w_q < w1_q) begin
          w_d     = w_q + XW'(1);
          xbase_d = xbase_q + XW'(PPW);
          state_d = RD_REQ;
        end else if ((RW'(r_q + RW'(1)) < RW'(SPRITE_H)) && ((y_q + XW'(1)) < XW'(SCREEN_H))) begin
          r_d        = r_q + RW'(1);
          y_d        = y_q + XW'(1);
          row_base_d = row_base_q + AW'(SPRITE_W);
          w_d        = w0_q;
          xbase_d    = xb0_q;
          state_d    = RD_REQ;
        end else begin
          state_d = DONE;
        end
        if (state_d == DONE) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      DONE: begin
        if (!Start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == RD_WAIT || state_q == MERGE) && (a_slot < MW'(PPW))) begin
      rom_addr_d = ok_a ? (row_base_q + AW'(col_a)) : row_base_q;
    end

    mem_req_d  = (state_d == RD_REQ) || (state_d == WR_REQ);
    mem_we_n_d = (state_d != WR_REQ);
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Rom_Sel   = sel_q;
  assign Rom_Addr  = rom_addr_q;
  assign Mem_Req   = mem_req_q;
  assign Mem_WE_N  = mem_we_n_q;
  assign Mem_Addr  = {1'b0, bsel_q, y_q[9:0], w_q[7:0]};
  assign Mem_Wdata = buf_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed checks of sprite_blitter (16x16 sprites, 4-bit pixels,
// 16-bit words) against a pixel-level reference and hand-computed SRAM words.
`timescale 1ns/1ps
module tb_sprite_blitter;

  logic        Clk = 1'b0;
  logic        Reset_N, Start, Back_Sel;
  logic [0:0]  Sprite_Id;
  logic [9:0]  ImgX, ImgY;
  logic        Busy, Done, Mem_Req, Mem_WE_N;
  logic [0:0]  Rom_Sel;
  logic [11:0] Rom_Addr;
  logic [3:0]  Rom_Data = 4'd0;
  logic        Mem_Gnt;
  logic [19:0] Mem_Addr;
  logic [15:0] Mem_Wdata;
  logic [15:0] Mem_Rdata = 16'd0;
`ifdef SPRITE_BLITTER_FLIP_EN
  logic        flip_x = 1'b0;
`endif

  int n_chk = 0;
  int n_bad = 0;

  logic [15:0]  sram    [int unsigned];
  logic [15:0]  exp_mem [int unsigned];
  bit           touched [int unsigned];
  int unsigned  wr_log[$];
  int unsigned  rd_log[$];

  sprite_blitter dut (
    .Clk(Clk), .Reset_N(Reset_N),
`ifdef SPRITE_BLITTER_FLIP_EN
    .Flip_X(flip_x),
`endif
    .Start(Start), .Sprite_Id(Sprite_Id), .ImgX(ImgX), .ImgY(ImgY), .Back_Sel(Back_Sel),
    .Busy(Busy), .Done(Done), .Rom_Sel(Rom_Sel), .Rom_Addr(Rom_Addr), .Rom_Data(Rom_Data),
    .Mem_Req(Mem_Req), .Mem_Gnt(Mem_Gnt), .Mem_WE_N(Mem_WE_N), .Mem_Addr(Mem_Addr),
    .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_init(input int unsigned a);
    return 16'(a) ^ 16'hBEEF;
  endfunction

  function automatic logic [15:0] sram_rd(input int unsigned a);
    return sram.exists(a) ? sram[a] : mem_init(a);
  endfunction

  function automatic logic [15:0] exp_rd(input int unsigned a);
    return exp_mem.exists(a) ? exp_mem[a] : mem_init(a);
  endfunction

  // sprite 0: never transparent; sprite 1: column 3 transparent
  function automatic logic [3:0] rom_pix(input logic [0:0] id, input int unsigned r, input int unsigned c);
    if (id == 1'b1 && c == 3) return 4'd0;
    return 4'(((r + c) % 15) + 1);
  endfunction

  function automatic int unsigned log_at(input int unsigned q[$], input int unsigned i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  // ROM: data one cycle after address
  always @(posedge Clk)
    Rom_Data <= rom_pix(Rom_Sel, int'(Rom_Addr) / 16, int'(Rom_Addr) % 16);

  // SRAM behind the arbiter: access happens in the grant cycle
  always @(posedge Clk) begin
    if (Mem_Req && Mem_Gnt) begin
      if (Mem_WE_N) begin
        Mem_Rdata <= sram_rd(Mem_Addr);
        rd_log.push_back(Mem_Addr);
      end else begin
        sram[Mem_Addr] = Mem_Wdata;
        wr_log.push_back(Mem_Addr);
      end
    end
  end

  // pixel-centric expectation of what the blit leaves in SRAM
  task automatic apply_ref(input logic [0:0] id, input int unsigned x, input int unsigned y, input logic bs);
    touched.delete();
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        int unsigned px, py, a;
        logic [15:0] w;
        logic [3:0]  p;
        px = x + c;
        py = y + r;
        if (px < 640 && py < 480) begin
          a = (int'(bs) << 18) | (py << 8) | (px / 4);
          touched[a] = 1'b1;
          p = rom_pix(id, r, c);
          if (p != 4'd0) begin
            w = exp_rd(a);
            w[(px % 4) * 4 +: 4] = p;
            exp_mem[a] = w;
          end
        end
      end
    end
  endtask

  task automatic launch(input logic [0:0] id, input int unsigned x, input int unsigned y,
                        input logic bs, input bit hold);
    Sprite_Id = id; ImgX = 10'(x); ImgY = 10'(y); Back_Sel = bs; Start = 1'b1;
    @(negedge Clk);
    chk("busy_at_launch", 32'(Busy), 1);
    ImgX = 10'd513; ImgY = 10'd77; Back_Sel = ~bs; Sprite_Id = ~id;
    if (!hold) Start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!Done && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, "_done"}, 32'(Done), 1);
  endtask

  task automatic wait_req(input string tag, input bit want_write);
    int n = 0;
    while (!(Mem_Req && (Mem_WE_N == !want_write)) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, "_req_seen"}, 32'(Mem_Req), 1);
  endtask

  // post-blit checks: traffic counts, address window, SRAM contents, Done release
  task automatic finish_blit(input string tag, input int unsigned wbase, input int unsigned rbase,
                             input int unsigned n_words);
    int bad_a = 0;
    int bad_w = 0;
    chk({tag, "_writes"}, 32'(wr_log.size() - wbase), n_words);
    chk({tag, "_reads"},  32'(rd_log.size() - rbase), n_words);
    chk({tag, "_busy_low"}, 32'(Busy), 0);
    for (int unsigned i = wbase; i < wr_log.size(); i++)
      if (!touched.exists(wr_log[i])) bad_a++;
    chk({tag, "_addr_window"}, 32'(bad_a), 0);
    foreach (touched[a]) if (sram_rd(a) !== exp_rd(a)) bad_w++;
    chk({tag, "_words"}, 32'(bad_w), 0);
    Start = 1'b0;
    @(negedge Clk);
    chk({tag, "_done_drop"}, 32'(Done), 0);
  endtask

  initial begin
    int unsigned wb, rb, a0;
    logic [15:0] d0;
    int err;

    Reset_N = 1'b0; Start = 1'b0; Sprite_Id = '0; ImgX = '0; ImgY = '0; Back_Sel = 1'b0;
    Mem_Gnt = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_req", 32'(Mem_Req), 0);
    chk("rst_we_n", 32'(Mem_WE_N), 1);
    chk("rst_rom_addr", 32'(Rom_Addr), 0);
    Reset_N = 1'b1;
    repeat (2) @(negedge Clk);

    // aligned 16x16 at (8,4) into back buffer 1
    wb = wr_log.size(); rb = rd_log.size();
    apply_ref(1'b0, 8, 4, 1'b1);
    launch(1'b0, 8, 4, 1'b1, 1'b0);
    wait_done("aligned");
    chk("aligned_first_rd", log_at(rd_log, rb), 32'h40402);
    chk("aligned_first_wr", log_at(wr_log, wb), 32'h40402);
    chk("aligned_word0", 32'(sram_rd(32'h40402)), 32'h4321);
    finish_blit("aligned", wb, rb, 64);

    // unaligned x=9: 5 words per row
    wb = wr_log.size(); rb = rd_log.size();
    apply_ref(1'b0, 9, 100, 1'b0);
    launch(1'b0, 9, 100, 1'b0, 1'b0);
    wait_done("unaligned");
    chk("unaligned_first_word", 32'(sram_rd(32'h06402)), 32'h321D);
    chk("unaligned_last_word", 32'(sram_rd(32'h06406)), 32'hDAE1);
    finish_blit("unaligned", wb, rb, 80);

    // transparency: sprite 1 column 3 is transparent
    wb = wr_log.size(); rb = rd_log.size();
    apply_ref(1'b1, 0, 200, 1'b1);
    launch(1'b1, 0, 200, 1'b1, 1'b0);
    wait_done("transp");
    chk("transp_word0", 32'(sram_rd(32'h4C800)), 32'h7321);
    chk("transp_word1", 32'(sram_rd(32'h4C801)), 32'h8765);
    finish_blit("transp", wb, rb, 64);

    // clipping at bottom-right corner
    wb = wr_log.size(); rb = rd_log.size();
    apply_ref(1'b0, 632, 472, 1'b0);
    launch(1'b0, 632, 472, 1'b0, 1'b0);
    wait_done("clip");
    chk("clip_first_wr", log_at(wr_log, wb), 32'h1D89E);
    chk("clip_word_159", 32'(sram_rd(32'h1D89F)), 32'h8765);
    chk("clip_last_row", 32'(sram_rd(32'h1DF9F)), 32'hFEDC);
    finish_blit("clip", wb, rb, 16);

    // fully off-screen: Busy pulse then Done, no SRAM traffic
    wb = wr_log.size(); rb = rd_log.size();
    apply_ref(1'b0, 100, 500, 1'b0);
    launch(1'b0, 100, 500, 1'b0, 1'b0);
    wait_done("offscreen");
    finish_blit("offscreen", wb, rb, 0);

    // arbitration stall on first read and first write, Start held high
    wb = wr_log.size(); rb = rd_log.size();
    apply_ref(1'b0, 40, 300, 1'b0);
    Mem_Gnt = 1'b0;
    launch(1'b0, 40, 300, 1'b0, 1'b1);
    wait_req("stall_rd", 1'b0);
    a0 = Mem_Addr;
    chk("stall_rd_addr", a0, 32'h12C0A);
    err = 0;
    repeat (50) begin
      @(negedge Clk);
      if (Mem_Req !== 1'b1 || Mem_WE_N !== 1'b1 || Mem_Addr !== 20'(a0)) err++;
    end
    chk("stall_rd_stable", 32'(err), 0);
    Mem_Gnt = 1'b1;
    @(negedge Clk);
    Mem_Gnt = 1'b0;
    wait_req("stall_wr", 1'b1);
    a0 = Mem_Addr; d0 = Mem_Wdata;
    chk("stall_wr_addr", a0, 32'h12C0A);
    chk("stall_wr_data", 32'(d0), 32'h4321);
    err = 0;
    repeat (50) begin
      @(negedge Clk);
      if (Mem_Req !== 1'b1 || Mem_WE_N !== 1'b0 || Mem_Addr !== 20'(a0) || Mem_Wdata !== d0) err++;
    end
    chk("stall_wr_stable", 32'(err), 0);
    chk("stall_no_early_wr", 32'(wr_log.size() - wb), 0);
    Mem_Gnt = 1'b1;
    wait_done("stall");
    err = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Done !== 1'b1 || Busy !== 1'b0 || Mem_Req !== 1'b0) err++;
    end
    chk("done_held_no_relaunch", 32'(err), 0);
    finish_blit("stall", wb, rb, 64);

    // reset while a write request is pending
    Mem_Gnt = 1'b0;
    launch(1'b0, 0, 350, 1'b0, 1'b0);
    wait_req("rst_mid_rd", 1'b0);
    Mem_Gnt = 1'b1;
    @(negedge Clk);
    Mem_Gnt = 1'b0;
    wait_req("rst_mid_wr", 1'b1);
    wb = wr_log.size();
    Reset_N = 1'b0;
    #1;
    chk("rst_mid_req", 32'(Mem_Req), 0);
    chk("rst_mid_busy", 32'(Busy), 0);
    chk("rst_mid_done", 32'(Done), 0);
    chk("rst_mid_we_n", 32'(Mem_WE_N), 1);
    Mem_Gnt = 1'b1;
    repeat (3) @(negedge Clk);
    Reset_N = 1'b1;
    repeat (5) @(negedge Clk);
    chk("rst_mid_no_write", 32'(wr_log.size() - wb), 0);
    chk("rst_mid_idle_req", 32'(Mem_Req), 0);
    chk("rst_mid_idle_busy", 32'(Busy), 0);
    chk("rst_mid_sram_kept", 32'(sram_rd(32'h15E00)), 32'(mem_init(32'h15E00)));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
